// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between instruction fetch (IF) and
// the load/store stage (DM). One fixed-latency access at a time, DM priority
// with a starvation guard for IF, one-cycle ready pulses and stage stalls.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        busy
);

  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GNT_IF,
    S_GNT_DM,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;
  logic          r_drop;
  logic          r_who_dm;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wstrb;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_dm_rdata;

  logic          w_grant_if;
  logic          w_grant_dm;
  logic          w_cnt_zero;
  logic          w_drop_now;

  // Arbitration and access-phase decode shared by FSM and datapath
  always_comb begin
    w_grant_if = (r_state == S_IDLE) && if_req && (!dm_req || (r_starve == STARVE_MAX));
    w_grant_dm = (r_state == S_IDLE) && dm_req && !w_grant_if;
    w_cnt_zero = (r_cnt == '0);
    // A flush on the final edge of a fetch still suppresses its result
    w_drop_now = r_drop || if_flush;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_if)      w_next = S_GNT_IF;
        else if (w_grant_dm) w_next = S_GNT_DM;
      end
      S_GNT_IF: if (w_cnt_zero) w_next = w_drop_now ? S_IDLE : S_RESP;
      S_GNT_DM: if (w_cnt_zero) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs: ready pulses in RESP, stalls and busy
  always_comb begin
    if_ready  = (r_state == S_RESP) && !r_who_dm;
    dm_ready  = (r_state == S_RESP) &&  r_who_dm;
    busy      = (r_state != S_IDLE);
    stall_if  = if_req && !if_ready;
    stall_mem = dm_req && !dm_ready;
  end

  // Memory port, latency counter, flush flag and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_who_dm    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_if) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_cnt       <= CNT_INIT;
            r_drop      <= if_flush;
            r_who_dm    <= 1'b0;
          end else if (w_grant_dm) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_mem_wstrb <= dm_wstrb;
            r_cnt       <= CNT_INIT;
            r_drop      <= 1'b0;
            r_who_dm    <= 1'b1;
          end
        end
        S_GNT_IF: begin
          if (w_cnt_zero) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            r_drop      <= 1'b0;
            if (!w_drop_now) r_if_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (if_flush) r_drop <= 1'b1;
          end
        end
        S_GNT_DM: begin
          if (w_cnt_zero) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            if (!r_mem_we) r_dm_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: consecutive DM grants made over a waiting fetch
  always_ff @(posedge clk) begin
    if (rst)                                     r_starve <= '0;
    else if (!if_req || w_grant_if)              r_starve <= '0;
    else if (w_grant_dm && r_starve != STARVE_MAX) r_starve <= r_starve + 1'b1;
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_mem_arbiter;

  localparam int L  = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem, busy;
  logic [3:0]  mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  // Memory contents as seen by the arbiter
  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0050_0093;
      32'h0000_0100: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign mem_rdata = memf(mem_addr);

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked by its age in cycles
  // since the grant edge (age 1..L = memory phase, age L+1 = response).
  bit          m_act, m_dm, m_drop, m_we;
  int          m_age, m_starve;
  logic [31:0] m_addr, m_wdata, m_ifd, m_dmd;
  logic [3:0]  m_wstrb;

  always @(posedge clk) begin : model
    bit was_idle, gi, gd;
    if (rst) begin
      m_act = 0; m_dm = 0; m_drop = 0; m_we = 0; m_age = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_wstrb = '0; m_ifd = '0; m_dmd = '0;
    end else begin
      was_idle = !m_act;
      if (m_act) begin
        if (!m_dm && if_flush && m_age <= L) m_drop = 1;
        if (m_age == L) begin
          if (!m_dm && !m_drop) m_ifd = memf(m_addr);
          if (m_dm && !m_we)    m_dmd = memf(m_addr);
          if (!m_dm && m_drop) begin m_act = 0; m_drop = 0; end
          else m_age++;
        end else if (m_age == L + 1) begin
          m_act = 0;
        end else begin
          m_age++;
        end
      end
      gi = was_idle && if_req && (!dm_req || m_starve == SL);
      gd = was_idle && dm_req && !gi;
      if (gi || gd) begin
        m_act   = 1;
        m_age   = 1;
        m_dm    = gd;
        m_addr  = gd ? dm_addr : if_addr;
        m_wdata = dm_wdata;
        m_we    = gd && dm_we;
        m_wstrb = gd ? dm_wstrb : 4'b0;
        m_drop  = gi && if_flush;
      end
      if (!if_req || gi) m_starve = 0;
      else if (gd && m_starve < SL) m_starve++;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin : compare
    bit e_en, e_rdy;
    if (chk_en) begin
      e_en  = m_act && m_age <= L;
      e_rdy = m_act && m_age == L + 1;
      chk1("mem_en", mem_en, e_en);
      chk1("mem_we", mem_we, e_en && m_we);
      chk32("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_en ? m_wstrb : 4'b0});
      if (e_en) chk32("mem_addr", mem_addr, m_addr);
      if (e_en && m_dm) chk32("mem_wdata", mem_wdata, m_wdata);
      chk1("if_ready", if_ready, e_rdy && !m_dm);
      chk1("dm_ready", dm_ready, e_rdy && m_dm);
      chk32("if_rdata", if_rdata, m_ifd);
      chk32("dm_rdata", dm_rdata, m_dmd);
      chk1("busy", busy, m_act);
      chk1("stall_if", stall_if, if_req && !(e_rdy && !m_dm));
      chk1("stall_mem", stall_mem, dm_req && !(e_rdy && m_dm));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          we_cnt;
    bit          prev_en, got;
    logic [31:0] gaddr[$];

    rst = 1; if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    step();
    chk_en = 1;
    step();
    rst = 0;

    // Reset values hold with no requests
    for (int k = 0; k < 3; k++) begin
      samp();
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_if_rdata", if_rdata, 32'h0);
      chk32("rst_dm_rdata", dm_rdata, 32'h0);
      step();
    end

    // Single fetch
    if_req = 1; if_addr = 32'h10;
    samp(); chk1("f_stall0", stall_if, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      step(); samp();
      chk1("f_en", mem_en, 1'b1);
      chk32("f_addr", mem_addr, 32'h10);
      chk1("f_stall", stall_if, 1'b1);
    end
    step(); samp();
    chk1("f_ready", if_ready, 1'b1);
    chk32("f_rdata", if_rdata, 32'h0050_0093);
    chk1("f_stall3", stall_if, 1'b0);
    #1 if_req = 0;
    step(); samp(); chk1("f_idle", busy, 1'b0);
    step();

    // Starvation: IF waits behind back-to-back DM loads
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    prev_en = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      samp();
      if (mem_en && !prev_en) gaddr.push_back(mem_addr);
      prev_en = mem_en;
      if (if_ready) begin
        got = 1;
        #1 if_req = 0; dm_req = 0;
      end
      step();
    end
    chk1("starve_if_done", got, 1'b1);
    chk32("starve_ngrants", gaddr.size(), 32'd5);
    for (int i = 0; i < gaddr.size() && i < 5; i++)
      chk32("starve_order", gaddr[i], (i < 4) ? 32'h300 : 32'h40);

    // Simultaneous requests: DM first, then IF
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    step(); step(); step(); samp();
    chk1("s_dm_ready", dm_ready, 1'b1);
    chk32("s_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk1("s_stall_if", stall_if, 1'b1);
    #1 dm_req = 0;
    step(); samp(); chk1("s_en4", mem_en, 1'b0);
    step(); samp(); chk1("s_en5", mem_en, 1'b1); chk32("s_addr5", mem_addr, 32'h20);
    step(); step(); samp();
    chk1("s_if_ready", if_ready, 1'b1);
    chk32("s_if_rdata", if_rdata, 32'h1357_9BFF);
    #1 if_req = 0;
    step();

    // Store
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hCAFE_F00D; dm_wstrb = 4'hF;
    we_cnt = 0;
    for (int c = 0; c <= 3; c++) begin
      samp();
      if (mem_we) we_cnt++;
      if (c == 1) begin
        chk32("st_wdata", mem_wdata, 32'hCAFE_F00D);
        chk32("st_wstrb", {28'b0, mem_wstrb}, 32'hF);
      end
      if (c == 3) begin
        chk1("st_ready", dm_ready, 1'b1);
        chk32("st_rdata_kept", dm_rdata, 32'hDEAD_BEEF);
      end
      if (c < 3) step();
    end
    #1 dm_req = 0; dm_we = 0; dm_wstrb = '0;
    chk32("st_we_cycles", we_cnt, 32'd2);
    step();

    // Flush in cycle 1 of a fetch
    if_req = 1; if_addr = 32'h50;
    step();
    if_flush = 1;
    step();
    if_flush = 0; if_req = 0;
    samp(); chk1("fl_noready2", if_ready, 1'b0);
    step(); samp();
    chk1("fl_busy3", busy, 1'b0);
    chk1("fl_noready3", if_ready, 1'b0);
    chk32("fl_rdata_kept", if_rdata, 32'h1357_9BFF);
    step();

    // Reset during GNT_DM
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    step(); samp(); chk1("rr_en1", mem_en, 1'b1);
    #1 rst = 1;
    step();
    rst = 0; dm_req = 0;
    samp();
    chk1("rr_en2", mem_en, 1'b0);
    chk1("rr_busy2", busy, 1'b0);
    chk1("rr_noready2", dm_ready, 1'b0);
    chk32("rr_dm_rdata", dm_rdata, 32'h0);
    step(); samp(); chk1("rr_noready3", dm_ready, 1'b0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch path and the data-memory (load/store) stage of the pipelined core. It grants the shared memory to one requester at a time and sequences each fixed-latency access through a small FSM. It returns read data with a one-cycle ready pulse and produces stall signals that hold the fetch and memory stages while they wait. It sits between `fetch`/the MEM stage and the unified instruction/data memory.

## Interface
- `MEM_LATENCY`, 2: edges `mem_en` must be held before `mem_rdata` is valid (≥1)
- `STARVE_LIMIT`, 4: consecutive DM grants that may pass over a pending IF request (≥1)
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1: fetch request; held until `if_ready`
- `if_addr` in 32: fetch address; stable while `if_req`
- `if_flush` in 1: drop the in-flight fetch result (branch redirect)
- `if_rdata` out 32: fetched instruction; valid when `if_ready`
- `if_ready` out 1: one-cycle completion pulse for fetch
- `dm_req` in 1: data request; held until `dm_ready`
- `dm_we` in 1: 1 = store, 0 = load
- `dm_addr` in 32, `dm_wdata` in 32, `dm_wstrb` in 4: data access attributes; stable while `dm_req`
- `dm_rdata` out 32: load data; valid when `dm_ready` after a load
- `dm_ready` out 1: one-cycle completion pulse for data
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: memory port, all registered
- `mem_rdata` in 32: memory read data
- `stall_if` out 1: `if_req & ~if_ready` (combinational)
- `stall_mem` out 1: `dm_req & ~dm_ready` (combinational)
- `busy` out 1: FSM not in IDLE

## Operation
- The FSM has four states: IDLE, GNT_IF, GNT_DM, RESP.
- **IDLE**
  - The winner is chosen, its attributes are latched into `mem_*`, `mem_en` goes to 1, `cnt` is set to MEM_LATENCY-1, and the FSM moves to GNT_x.
  - Priority: DM beats IF, except when `starve_cnt` = STARVE_LIMIT and `if_req` is high; then IF wins.
- **Starvation counter**
  - `starve_cnt` increments, saturating, on each DM grant made while `if_req` is high.
  - It clears on any IF grant.
  - It clears on any cycle where `if_req` is low.
- **GNT_x**
  - `mem_*` are held constant.
  - While `cnt` ≠ 0, `cnt` decrements.
  - At `cnt` = 0:
    - capture `mem_rdata` into `if_rdata` (GNT_IF) or into `dm_rdata` (GNT_DM load only; stores leave `dm_rdata` unchanged);
    - drop `mem_en`, `mem_we` and `mem_wstrb` to 0;
    - go to RESP.
- **RESP**
  - The matching ready is 1 for exactly this cycle and no grant is made.
  - The FSM returns to IDLE, which gives the requester one edge to drop or renew `req`.
- **Write access**
  - `mem_we` = `dm_we` and `mem_wstrb` = `dm_wstrb` only in GNT_DM.
  - Both are 0 in all other states.
- **Flush**
  - `if_flush` high at any edge during GNT_IF, or in IDLE together with an IF grant, sets `drop`.
  - With `drop` set, at `cnt` = 0 the FSM goes directly to IDLE. No `if_ready` is produced and `if_rdata` is not updated. `drop` then clears.
  - `if_flush` in other states has no effect.
- **Address and data**
  - Addresses pass through unmodified; no alignment checks.
  - Data width is fixed at 32 bits.

## Timing
- **Reset values**: state IDLE; all `mem_*` = 0; `if_rdata` = `dm_rdata` = 0; `if_ready` = `dm_ready` = 0; `busy` = 0; `cnt` = `starve_cnt` = 0; `drop` = 0.
- **Reset mid-transaction**: the transaction is abandoned and there is no ready pulse. `mem_en` is 0 in the cycle after the reset edge.
- **Latency**: with the request first high in cycle 0 and the arbiter idle, the grant edge ends cycle 0. `mem_en` is high in cycles 1..MEM_LATENCY. Ready is high in cycle MEM_LATENCY+1.
- **Throughput**: minimum MEM_LATENCY+2 cycles per access. `mem_en` is low for at least two cycles (RESP, then IDLE) between accesses.
- **Simultaneous requests** in IDLE: DM is granted (subject to the starvation rule). IF keeps `stall_if` high.
- **Request dropped before grant**: a request deasserted before it is sampled in IDLE is never serviced.
- **Protocol violations**: deasserting a request after grant, or changing its attributes, does not affect the in-flight access. That access completes and still pulses ready.

## Test plan
- **Reset values**: `rst` high for 2 cycles, then released with no requests → all outputs 0, `busy` = 0, `mem_en` stays 0.
- **Single fetch** (MEM_LATENCY=2): `if_req`=1, `if_addr`=0x10; memory returns 0x00500093 → `mem_en`=1 with `mem_addr`=0x10 in cycles 1–2; `if_ready`=1 and `if_rdata`=0x00500093 in cycle 3; `stall_if` 1 in cycles 0–2.
- **Simultaneous requests**: IF at 0x20 and DM load at 0x100 (memory returns 0xDEADBEEF) issued together → DM served first, `dm_ready` in cycle 3 with `dm_rdata`=0xDEADBEEF; IF `mem_en` from cycle 5; `if_ready` in cycle 7.
- **Store**: `dm_we`=1, `dm_addr`=0x200, `dm_wdata`=0xCAFEF00D, `dm_wstrb`=0xF → `mem_we`=1 for exactly 2 cycles, `dm_ready` pulses, `dm_rdata` unchanged.
- **Starvation**: `if_req` held high while DM issues back-to-back loads → IF granted after the 4th DM grant; `starve_cnt` returns to 0.
- **Flush and mid-access reset**:
  - `if_flush` pulsed in cycle 1 of a fetch → no `if_ready`; `busy`=0 in cycle 3.
  - `rst` during GNT_DM → `mem_en`=0 next cycle, no `dm_ready`.
